dmem_responder: RTL and testbench

Data-memory responder serving the load/store requests that leave the EX/MEM pipeline register. It samples `MemRd`/`MemWr`, address (ALU result) and store data, services them from a word-addressed RAM after a configurable number of wait states, and drives `mem_stall` back to the pipeline. While `mem_stall` is high, the hazard logic holds the PC, IF/ID, ID/EX and EX/MEM. The MEM/WB register captures `RdData` on the response cycle.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_array.sv | 21 ++
 rtl/dmem_responder.sv | 130 +++++++++++++
 tb/tb_dmem_responder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_RD,
    OP_WR
  } op_t;

  localparam int WORD_BYTES = 4;
  localparam int CNT_W      = 4;

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM: combinational read, synchronous write, storage never reset.
module dmem_array #(
  parameter  int DEPTH_WORDS = 256,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with fixed wait states and a pipeline stall request.
// Optional build macro: DMEM_ALIGN_CHECK_EN treats Addr[1:0]!=0 as an access error.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [31:0] Addr,
  input  logic [31:0] WrData,
  output logic [31:0] RdData,
  output logic        mem_stall,
  output logic        mem_done,
  output logic        addr_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  state_t           state;
  op_t              op_q;
  logic [CNT_W-1:0] cnt;
  logic [AW-1:0]    idx_q;
  logic [31:0]      wdata_q;
  logic             bad_q;
  logic             both_q;

  logic             req;
  logic             bad_in;
  logic [AW-1:0]    idx_in;
  logic [AW-1:0]    arr_idx;
  logic [31:0]      arr_rdata;
  logic             arr_we;
  logic             go_resp;
  logic             resp_rd;
  logic             resp_bad;
  logic             resp_both;

  assign req    = MemRd | MemWr;
  assign idx_in = Addr[AW+1:2];

  always_comb begin
    bad_in = |Addr[31:AW+2];
`ifdef DMEM_ALIGN_CHECK_EN
    bad_in = bad_in | (|Addr[1:0]);
`endif
  end

`ifndef DMEM_ALIGN_CHECK_EN
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^Addr[1:0];
`endif

  // With zero wait states the response is formed straight from the live request,
  // otherwise from the captured copy.
  assign go_resp   = (state == IDLE && req && WAIT_CYCLES == 0) ||
                     (state == WAIT && cnt == '0);
  assign resp_rd   = (state == IDLE) ? MemRd              : (op_q == OP_RD);
  assign resp_bad  = (state == IDLE) ? bad_in             : bad_q;
  assign resp_both = (state == IDLE) ? (MemRd & MemWr)    : both_q;

  assign arr_idx   = (state == IDLE) ? idx_in : idx_q;
  assign arr_we    = (state == RESP) && (op_q == OP_WR) && !bad_q;

  assign mem_stall = (state == WAIT) || (state == IDLE && req);

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .addr (arr_idx),
    .wdata(wdata_q),
    .rdata(arr_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      op_q     <= OP_NONE;
      cnt      <= '0;
      RdData   <= '0;
      mem_done <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      mem_done <= 1'b0;
      addr_err <= 1'b0;
      if (go_resp) begin
        mem_done <= 1'b1;
        addr_err <= resp_bad | resp_both;
        if (resp_rd) RdData <= resp_bad ? 32'h0 : arr_rdata;
      end
      case (state)
        IDLE: begin
          if (req) begin
            op_q <= MemRd ? OP_RD : OP_WR;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) state <= RESP;
          else           cnt   <= cnt - 1'b1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Request payload is plain data; a reset discards it by returning the FSM to IDLE.
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      idx_q   <= idx_in;
      wdata_q <= WrData;
      bad_q   <= bad_in;
      both_q  <= MemRd & MemWr;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a 2-wait-state instance and a 0-wait-state instance.
module tb_dmem_responder;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_a, wr_a, rd_b, wr_b;
  logic [31:0] addr_a, wdata_a, addr_b, wdata_b;
  logic [31:0] rdata_a, rdata_b;
  logic        stall_a, done_a, err_a, stall_b, done_b, err_b;

  exp_t        sb_a[$];
  exp_t        sb_b[$];
  logic [31:0] model_a [256];
  logic [31:0] model_b [256];
  logic [31:0] last_a, last_b;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset), .MemRd(rd_a), .MemWr(wr_a), .Addr(addr_a), .WrData(wdata_a),
    .RdData(rdata_a), .mem_stall(stall_a), .mem_done(done_a), .addr_err(err_a)
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .MemRd(rd_b), .MemWr(wr_b), .Addr(addr_b), .WrData(wdata_b),
    .RdData(rdata_b), .mem_stall(stall_b), .mem_done(done_b), .addr_err(err_b)
  );

  function automatic logic bad_addr(input logic [31:0] a);
    logic b;
    b = (a[31:10] != 22'h0);
`ifdef DMEM_ALIGN_CHECK_EN
    b = b | (a[1:0] != 2'b00);
`endif
    return b;
  endfunction

  task automatic push_a(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    logic bad;
    bad   = bad_addr(a);
    e.err = bad | (rd & wr);
    if (rd)        last_a = bad ? 32'h0 : model_a[a[9:2]];
    else if (!bad) model_a[a[9:2]] = d;
    e.data = last_a;
    sb_a.push_back(e);
  endtask

  task automatic push_b(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    logic bad;
    bad   = bad_addr(a);
    e.err = bad | (rd & wr);
    if (rd)        last_b = bad ? 32'h0 : model_b[a[9:2]];
    else if (!bad) model_b[a[9:2]] = d;
    e.data = last_b;
    sb_b.push_back(e);
  endtask

  task automatic run_access(input string name, input logic rd, input logic wr,
                            input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int   cyc;
    int   stall_cnt;
    push_a(rd, wr, a, d);
    @(negedge clk);
    rd_a = rd; wr_a = wr; addr_a = a; wdata_a = d;
    #1;
    cyc = 0;
    stall_cnt = 0;
    while (done_a !== 1'b1 && cyc < 40) begin
      if (stall_a === 1'b1) stall_cnt++;
      @(posedge clk); #1;
      rd_a = 1'b0; wr_a = 1'b0; addr_a = 32'hFFFF_FFFC; wdata_a = 32'h0;
      cyc++;
    end
    e = sb_a.pop_front();
    checks++;
    if (done_a !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: mem_done never rose within %0d cycles", name, cyc);
    end else begin
      checks++;
      if (cyc !== 3 || stall_cnt !== 3) begin
        errors++;
        $display("FAIL %s latency: done after %0d edges, stall %0d cycles, need 3 and 3", name, cyc, stall_cnt);
      end
      checks++;
      if (rdata_a !== e.data || err_a !== e.err || stall_a !== 1'b0) begin
        errors++;
        $display("FAIL %s resp: RdData=%h addr_err=%b stall=%b, need RdData=%h addr_err=%b stall=0",
                 name, rdata_a, err_a, stall_a, e.data, e.err);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (done_a !== 1'b0 || err_a !== 1'b0 || rdata_a !== e.data) begin
      errors++;
      $display("FAIL %s after: done=%b addr_err=%b RdData=%h, need 0 0 %h", name, done_a, err_a, rdata_a, e.data);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rdata_a !== 32'h0 || stall_a !== 1'b0 || done_a !== 1'b0 || err_a !== 1'b0 ||
        rdata_b !== 32'h0 || stall_b !== 1'b0 || done_b !== 1'b0 || err_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals: A=%h/%b/%b/%b B=%h/%b/%b/%b, need all zero",
               rdata_a, stall_a, done_a, err_a, rdata_b, stall_b, done_b, err_b);
    end
    @(negedge clk);
    reset = 1'b0;
    last_a = 32'h0;
    last_b = 32'h0;
  endtask

  task automatic test_write_read();
    run_access("wr_10", 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    run_access("rd_10", 1'b1, 1'b0, 32'h10, 32'h0);
    run_access("wr_14", 1'b0, 1'b1, 32'h14, 32'h0123_4567);
    run_access("rd_14", 1'b1, 1'b0, 32'h14, 32'h0);
  endtask

  task automatic test_zero_wait();
    logic        rd_t [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] a_t  [4] = '{32'h0, 32'h4, 32'h0, 32'h4};
    logic [31:0] d_t  [4] = '{32'h0000_00A0, 32'h0000_00B4, 32'h0, 32'h0};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      push_b(rd_t[i], ~rd_t[i], a_t[i], d_t[i]);
      @(negedge clk);
      rd_b = rd_t[i]; wr_b = ~rd_t[i]; addr_b = a_t[i]; wdata_b = d_t[i];
      #1;
      checks++;
      if (stall_b !== 1'b1 || done_b !== 1'b0) begin
        errors++;
        $display("FAIL zw_accept%0d: stall=%b done=%b, need 1 0", i, stall_b, done_b);
      end
      @(negedge clk); #1;
      e = sb_b.pop_front();
      checks++;
      if (done_b !== 1'b1 || stall_b !== 1'b0 || rdata_b !== e.data || err_b !== e.err) begin
        errors++;
        $display("FAIL zw_resp%0d: done=%b stall=%b RdData=%h addr_err=%b, need 1 0 %h %b",
                 i, done_b, stall_b, rdata_b, err_b, e.data, e.err);
      end
    end
    @(negedge clk);
    rd_b = 1'b0; wr_b = 1'b0;
    #1;
    checks++;
    if (stall_b !== 1'b0 || done_b !== 1'b0 || rdata_b !== 32'h0000_00B4) begin
      errors++;
      $display("FAIL zw_idle: stall=%b done=%b RdData=%h, need 0 0 000000b4", stall_b, done_b, rdata_b);
    end
  endtask

  task automatic test_out_of_range();
    run_access("wr_0",      1'b0, 1'b1, 32'h0,   32'h0BAD_0000);
    run_access("wr_400",    1'b0, 1'b1, 32'h400, 32'h1234_5678);
    run_access("rd_400",    1'b1, 1'b0, 32'h400, 32'h0);
    run_access("rd_0",      1'b1, 1'b0, 32'h0,   32'h0);
    run_access("rd_high",   1'b1, 1'b0, 32'h8000_0010, 32'h0);
  endtask

  task automatic test_simultaneous();
    run_access("wr_8",      1'b0, 1'b1, 32'h8, 32'h11);
    run_access("rdwr_8",    1'b1, 1'b1, 32'h8, 32'h99);
    run_access("rd_8",      1'b1, 1'b0, 32'h8, 32'h0);
  endtask

  task automatic test_misaligned();
    run_access("wr_4",      1'b0, 1'b1, 32'h4, 32'h0000_0444);
    run_access("rd_6",      1'b1, 1'b0, 32'h6, 32'h0);
  endtask

  task automatic test_reset_mid();
    run_access("wr_20",     1'b0, 1'b1, 32'h20, 32'hCAFE_0001);
    run_access("rd_20",     1'b1, 1'b0, 32'h20, 32'h0);
    @(negedge clk);
    wr_a = 1'b1; addr_a = 32'h20; wdata_a = 32'hAAAA_5555;
    @(posedge clk); #1;
    wr_a = 1'b0; addr_a = 32'h0; wdata_a = 32'h0;
    checks++;
    if (stall_a !== 1'b1) begin
      errors++;
      $display("FAIL mid_wait: stall=%b, need 1", stall_a);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (rdata_a !== 32'h0 || stall_a !== 1'b0 || done_a !== 1'b0 || err_a !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: RdData=%h stall=%b done=%b addr_err=%b, need all zero",
               rdata_a, stall_a, done_a, err_a);
    end
    @(negedge clk);
    reset = 1'b0;
    last_a = 32'h0;
    last_b = 32'h0;
    run_access("rd_20_post", 1'b1, 1'b0, 32'h20, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    rd_a = 1'b0; wr_a = 1'b0; addr_a = 32'h0; wdata_a = 32'h0;
    rd_b = 1'b0; wr_b = 1'b0; addr_b = 32'h0; wdata_b = 32'h0;
    test_reset();
    test_write_read();
    test_zero_wait();
    test_out_of_range();
    test_simultaneous();
    test_misaligned();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
